// File: rtl/intersection_pkg.sv
// Shared types and default timing constants for the intersection sequencer.
package intersection_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    CLEAR     = 3'd3,
    ALL_RED   = 3'd4,
    SERVICE   = 3'd5
  } state_t;

  localparam int DEF_ALL_RED_CYCLES  = 3;
  localparam int DEF_WATCHDOG_CYCLES = 255;

endpackage

// File: rtl/intersection_sequencer_ped_req_latch.sv
// Per-direction pedestrian request latch: set on a button press, cleared when
// the direction is released; a press coinciding with the release is kept.
module ped_req_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic req
);

  // set dominates clear so a press during the release cycle is not lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   req <= 1'b0;
    else if (set) req <= 1'b1;
    else if (clr) req <= 1'b0;
  end

endmodule

// File: rtl/intersection_sequencer.sv
// Round-robin right-of-way sequencer for the signal units of one intersection.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | first cycle after reset, nothing granted yet
// START     | one-cycle enable pulse to the unit of the current direction
// WAIT_DONE | waiting for the active unit's done level, watchdog running
// CLEAR     | one-cycle release pulse to the active unit
// ALL_RED   | all-red gap before the next direction is granted
// SERVICE   | blinking-yellow service mode (also held while faulted)
module intersection_sequencer
  import intersection_pkg::*;
#(
  parameter int NUM_DIR         = 2,
  parameter int ALL_RED_CYCLES  = DEF_ALL_RED_CYCLES,
  parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       service_i,
  input  logic [NUM_DIR-1:0]         pietoni_btn_i,
  input  logic [NUM_DIR-1:0]         done_i,
  output logic [NUM_DIR-1:0]         enable_o,
  output logic [NUM_DIR-1:0]         clear_o,
  output logic [NUM_DIR-1:0]         pietoni_req_o,
  output logic                       service_o,
  output logic [$clog2(NUM_DIR)-1:0] active_dir_o,
  output logic                       fault_o
);

  localparam int DIR_W = $clog2(NUM_DIR);
  localparam int AR_W  = $clog2(ALL_RED_CYCLES + 1);
  localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);

  localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIR - 1);
  localparam logic [AR_W-1:0]  AR_LAST  = AR_W'(ALL_RED_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(WATCHDOG_CYCLES);

  state_t           state, state_nxt;
  logic [DIR_W-1:0] dir;
  logic [AR_W-1:0]  ar_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic             fault;
  logic             skip_inc;   // set when leaving SERVICE: grant dir 0 without advancing
  logic             done_act;
  logic             ar_last;
  logic             fault_set;

  // only the granted direction's done is looked at
  assign done_act  = done_i[dir];
  assign ar_last   = (ar_cnt == AR_LAST);
  // the fault is raised on the edge that ends the last allowed WAIT_DONE cycle
  assign fault_set = (state == WAIT_DONE) && (wd_cnt == WD_LAST) && !done_act;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode; service request and fault override everything
  always_comb begin
    state_nxt = state;
    if (service_i || fault || fault_set) begin
      state_nxt = SERVICE;
    end else begin
      case (state)
        IDLE:      state_nxt = START;
        START:     state_nxt = WAIT_DONE;
        WAIT_DONE: if (done_act) state_nxt = CLEAR;
        CLEAR:     state_nxt = ALL_RED;
        ALL_RED:   if (ar_last) state_nxt = START;
        SERVICE:   state_nxt = ALL_RED;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // direction pointer, all-red and watchdog counters, sticky fault
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir      <= '0;
      ar_cnt   <= '0;
      wd_cnt   <= '0;
      fault    <= 1'b0;
      skip_inc <= 1'b0;
    end else begin
      fault  <= fault | fault_set;
      ar_cnt <= (state == ALL_RED && !ar_last) ? ar_cnt + 1'b1 : '0;
      wd_cnt <= (state == WAIT_DONE && wd_cnt != WD_MAX) ? wd_cnt + 1'b1 : '0;
      if (state == SERVICE && state_nxt == ALL_RED) begin
        dir      <= '0;
        skip_inc <= 1'b1;
      end else if (state == ALL_RED && state_nxt == START) begin
        if (!skip_inc) dir <= (dir == LAST_DIR) ? '0 : dir + 1'b1;
        skip_inc <= 1'b0;
      end
    end
  end

  // Moore output decode
  always_comb begin
    enable_o  = '0;
    clear_o   = '0;
    if (state == START) enable_o[dir] = 1'b1;
    if (state == CLEAR) clear_o[dir]  = 1'b1;
    service_o = (state == SERVICE) || fault;
  end

  assign active_dir_o = dir;
  assign fault_o      = fault;

  for (genvar d = 0; d < NUM_DIR; d++) begin : g_ped
    ped_req_latch u_ped_req_latch (
      .clk   (clk),
      .rst_n (rst_n),
      .set   (pietoni_btn_i[d]),
      .clr   ((state == CLEAR) && (dir == DIR_W'(d))),
      .req   (pietoni_req_o[d])
    );
  end

endmodule

// File: doc/intersection_sequencer.md
# intersection_sequencer

Upstream controller for the per-direction vehicle/pedestrian signal units at one intersection. It grants the right-of-way to one direction at a time with an `enable`/`done`/`clear` handshake. It latches pedestrian button presses per direction until served and inserts an all-red interval between directions. It also fans out service (blinking-yellow) mode, and raises a sticky fault if a direction never reports completion.

## Interface
Parameters:
- `NUM_DIR`, default 2: number of directions/signal units; legal range 2..8.
- `ALL_RED_CYCLES`, default 3: length of the all-red gap between directions, in clk cycles; must be ≥1.
- `WATCHDOG_CYCLES`, default 255: maximum cycles spent in WAIT_DONE before a fault is raised.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `service_i`, in, 1: operator service request (level).
- `pietoni_btn_i`, in, NUM_DIR: pedestrian button per direction; synchronous, may be a single-cycle pulse.
- `done_i`, in, NUM_DIR: per-unit done level.
- `enable_o`, out, NUM_DIR: one-hot start pulse to the active unit.
- `clear_o`, out, NUM_DIR: one-hot release pulse to the active unit.
- `pietoni_req_o`, out, NUM_DIR: latched pedestrian request per unit (level).
- `service_o`, out, 1: service mode to all units.
- `active_dir_o`, out, $clog2(NUM_DIR): currently granted direction.
- `fault_o`, out, 1: sticky watchdog fault.

## Operation
- The block is a Moore FSM. Outputs are decoded from the state register, `dir` register, request latches and fault flag.
- States:
  - IDLE: left on the cycle after reset, goes to START.
  - START: `enable_o[dir]` = 1 for exactly 1 cycle, then WAIT_DONE.
  - WAIT_DONE: stays until `done_i[dir]`, then CLEAR.
  - CLEAR: `clear_o[dir]` = 1 for exactly 1 cycle, then ALL_RED.
  - ALL_RED: counts ALL_RED_CYCLES cycles. Then `dir` ← `dir`+1 (wraps NUM_DIR-1 → 0) and the FSM goes to START.
  - SERVICE: all `enable_o`/`clear_o` = 0 and `service_o` = 1. Leaves when `service_i` = 0, going to ALL_RED with `dir` forced to 0; there is no increment on that exit.
- `service_i` = 1 in any state other than SERVICE forces SERVICE on the next edge. This has priority over every other transition.
- Enable is a pulse, never a level, so a unit returning to idle after clear is not immediately restarted.
- Pedestrian latch, per direction d:
  - Set when `pietoni_btn_i[d]` = 1.
  - Cleared on the CLEAR cycle when `dir` = d.
  - If set and clear happen in the same cycle, set wins.
  - Latches are retained through SERVICE.
- Watchdog:
  - A counter runs only in WAIT_DONE and is reset on any other state.
  - When it reaches WATCHDOG_CYCLES, `fault_o` ← 1.
  - `fault_o` stays 1 until `rst_n`. While it is 1, `service_o` = 1 and the FSM is held in SERVICE regardless of `service_i`.
- A `done_i` bit of a non-active direction is ignored.

## Timing
- Reset values:
  - State IDLE; `dir` = 0; counters = 0; latches = 0.
  - All outputs 0, and `active_dir_o` = 0.
- Reset is asynchronous, and asserting it mid-operation returns the block to these values immediately.
- Cycle positions after reset release:
  - Release at edge 0; IDLE→START at edge 1.
  - `enable_o[0]` is high during the cycle after edge 1.
- `done_i` sampled high at edge n gives CLEAR after edge n, so `clear_o` is high during cycle n+1.
- The next direction's `enable_o` rises ALL_RED_CYCLES+1 cycles after `clear_o`.
- Latch latency: `pietoni_btn_i` at edge n → `pietoni_req_o` high from cycle n+1.
- `service_i` rising at edge n → `service_o` high from cycle n+1.
- Counter widths: $clog2(ALL_RED_CYCLES+1) and $clog2(WATCHDOG_CYCLES+1). Neither counter ever wraps; each saturates or resets on state exit.

## Structure
- A shared package `intersection_pkg` holds:
  - the state enum (IDLE, START, WAIT_DONE, CLEAR, ALL_RED, SERVICE);
  - default constants for ALL_RED_CYCLES and WATCHDOG_CYCLES.
- One natural sub-module: `ped_req_latch`, a per-direction set/clear latch with set priority, instantiated NUM_DIR times.
- The watchdog and all-red counters stay inline.

## Test plan
- Normal rotation, NUM_DIR=2, ALL_RED_CYCLES=3. Each unit model answers `done` 20 cycles after `enable`.
  - Required: `enable_o` sequence 01, 10, 01.
  - Required: `clear_o` exactly one cycle after each `done`.
  - Required: 4-cycle gap from `clear_o` to the next `enable_o`.
- Pedestrian latch:
  - `pietoni_btn_i`=2'b10 pulsed during dir 0's grant → `pietoni_req_o`=2'b10 held until dir 1's CLEAR, then 2'b00.
  - A press on the same cycle as that CLEAR leaves `pietoni_req_o[1]`=1.
- Service entry and exit:
  - `service_i`=1 during WAIT_DONE of dir 1 → `service_o`=1 next cycle and `enable_o`/`clear_o`=0.
  - After `service_i`=0 → `enable_o`=01 after 4 cycles.
- Watchdog: with WATCHDOG_CYCLES=10 and `done` withheld, `fault_o`=1 at cycle 11 of WAIT_DONE. `service_o` stays 1 even with `service_i`=0, until reset.
- Spurious done: `done_i[1]`=1 while dir 0 is active → no transition and no `clear_o`.
- Async reset: `rst_n`=0 in ALL_RED → all outputs 0 immediately; `enable_o`=01 one cycle after release.
